hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard and redirect controller for the 5-stage RISC-V core. It sits beside the IF/ID/EX stage registers and drives their write, flush and bubble controls. It sequences load-use stalls, PC redirects from EX-resolved branches and jumps (including stale-fetch flushing for a synchronous instruction memory), and data-memory wait freezes. It also keeps a saturating stall-cycle counter.

## Interface
- IMEM_LAT, 1: cycles after a redirect during which fetched instructions are stale and must be flushed (range 1–7).
- CNT_W, 16: width of the stall-cycle counter.
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- id_inst  in  32  instruction held in IF/ID.
- id_valid  in  1  IF/ID holds a real instruction.
- ex_valid  in  1  ID/EX holds a real instruction.
- ex_mem_read  in  1  EX instruction is a load.
- ex_rd  in  5  EX destination register.
- ex_redirect  in  1  EX resolved a taken branch, JAL or JALR; PC target is valid this cycle.
- mem_busy  in  1  data memory not ready; the MEM stage must hold.
- pc_write  out  1  PC register load enable.
- ifid_write  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID is cleared to a bubble on the next edge.
- idex_bubble  out  1  ID/EX is loaded with a bubble (all control zero).
- exmem_hold  out  1  EX/MEM and MEM/WB hold their contents.
- stall_cnt  out  CNT_W  count of cycles with pc_write=0, saturating.
- state  out  2  FSM state, for debug.

## Operation
- **Source-register use, decoded from id_inst[6:0]:**
  - R 0110011: rs1 and rs2.
  - I-ALU 0010011, load 0000011, JALR 1100111: rs1 only.
  - S 0100011 and B 1100011: rs1 and rs2.
  - JAL 1101111, LUI 0110111, AUIPC 0010111: none.
  - Any other opcode: none.
  - Register x0 never creates a hazard.
- **Load-use hazard (lu):** id_valid & ex_valid & ex_mem_read & ex_rd≠0 & (ex_rd matches a used rs1 or rs2).
- **States:** RUN=2'b00, LU_STALL=2'b01, FLUSH=2'b10, MEM_WAIT=2'b11. A 3-bit flush counter fcnt and a saved flag resume_flush support the FSM.
- **Per-cycle priority, highest first:**
  1. mem_busy: pc_write=0, ifid_write=0, exmem_hold=1, ifid_flush=0, idex_bubble=0. Go to MEM_WAIT. If the current state is FLUSH, set resume_flush=1 and leave fcnt unchanged.
  2. ex_redirect (any state, once busy is low): pc_write=1, ifid_flush=1, idex_bubble=1. Load fcnt=IMEM_LAT and go to FLUSH. A redirect arriving during FLUSH restarts fcnt.
  3. FLUSH with fcnt≠0: pc_write=1, ifid_flush=1, idex_bubble=0. Decrement fcnt, and go to RUN when it reaches 0.
  4. lu, only when the state is RUN: pc_write=0, ifid_write=0, idex_bubble=1. Go to LU_STALL.
  5. Otherwise: pc_write=1, ifid_write=1, all other controls 0. Go to RUN.
- **LU_STALL:** lu is masked for exactly one cycle, so each load-use inserts one bubble. The next state is RUN unless a higher-priority event occurs.
- **MEM_WAIT:** when mem_busy falls, go to FLUSH if resume_flush=1 (then clear the flag), else go to RUN. The outputs of that cycle follow the priority list above.
- **Masked hazards:** lu is ignored in FLUSH and in the exit cycle of MEM_WAIT, because the ID contents are either flushed or re-evaluated in RUN.
- **stall_cnt:** +1 on each edge with rst_n high and pc_write=0. It holds at 2^CNT_W−1.

## Timing
- **Reset:** while rst_n=0, regardless of clk:
  - state=RUN, fcnt=0, resume_flush=0, stall_cnt=0.
  - Outputs forced to pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, exmem_hold=0.
- **Mid-operation reset:** assertion aborts any stall, flush or wait immediately, with no pending state kept.
- **Control timing:** all controls are combinational from the current state and inputs, and take effect on the next rising edge. Hazard-to-control latency is 0 cycles.
- **Load-use cost:** exactly 1 stall cycle.
- **Redirect cost:** 1+IMEM_LAT flushed fetch slots.
- **mem_busy:** each busy cycle adds one frozen cycle. ex_redirect held by the frozen EX stage is honoured on the first non-busy cycle.

## Structure
- **Shared package hazard_pkg:**
  - State enum.
  - Opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC), shared with the decode-stage immediate generator.
- **Sub-module hazard_src_decode:** combinational. Input id_inst; outputs use_rs1, use_rs2, rs1, rs2.
- **Top-level contents:** the FSM, fcnt, resume_flush and stall_cnt.

## Test plan
- **Load-use:** EX `lw x5` (ex_mem_read=1, ex_rd=5), ID `add x6,x5,x1` → 1 cycle with pc_write=0 and idex_bubble=1, then RUN; stall_cnt=1. Repeat with ID `jal x5` → no stall.
- **x0 / no-use:** ex_rd=0, or ID `lui x5` with ex_rd=5 → no stall.
- **Redirect, IMEM_LAT=2:** pulse ex_redirect → 3 consecutive cycles with ifid_flush=1 and pc_write=1; idex_bubble=1 only in the first; state sequence FLUSH→FLUSH→RUN.
- **Simultaneous events:**
  - ex_redirect and lu in the same cycle → redirect outputs, no stall.
  - mem_busy and ex_redirect for 3 cycles → 3 freeze cycles, then the redirect.
- **Busy mid-flush:** IMEM_LAT=3, mem_busy raised at fcnt=2 for 4 cycles → MEM_WAIT for 4 cycles, then 2 remaining flush cycles.
- **Counter:** CNT_W=4 with 20 busy cycles → stall_cnt=15. Assert rst_n=0 mid-FLUSH → all reset values without a clock edge.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding
// and RV32 major opcodes (also consumed by the decode-stage immediate generator).
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    FLUSH    = 2'b10,
    MEM_WAIT = 2'b11
  } hz_state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

endpackage

// File: rtl/hazard_src_decode.sv
// Decodes which source registers the instruction in IF/ID actually reads,
// so that immediate bits sitting in the rs fields never raise a false hazard.
module hazard_src_decode
  import hazard_pkg::*;
(
  input  logic [31:0] id_inst,
  output logic        use_rs1,
  output logic        use_rs2,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2
);

  logic unused_bits;
  assign unused_bits = ^{id_inst[31:25], id_inst[14:7]};

  assign rs1 = id_inst[19:15];
  assign rs2 = id_inst[24:20];

  // Opcode-driven source usage.
  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (id_inst[6:0])
      OP_R, OP_STORE, OP_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_IMM, OP_LOAD, OP_JALR: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b0;
      end
      OP_JAL, OP_LUI, OP_AUIPC: begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
      end
      default: begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard and redirect controller: load-use stalls, EX redirects with stale-fetch
// flushing, data-memory wait freezes, and a saturating stall-cycle counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int IMEM_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      id_inst,
  input  logic             id_valid,
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_hold,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       state
);

  localparam logic [2:0]       FLUSH_INIT = 3'(IMEM_LAT);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  hz_state_t  cur_state, nxt_state;
  logic [2:0] fcnt, fcnt_nxt;
  logic       resume_flush, resume_nxt;
  logic       use_rs1, use_rs2;
  logic [4:0] rs1, rs2;
  logic       lu;

  hazard_src_decode u_src_decode (
    .id_inst (id_inst),
    .use_rs1 (use_rs1),
    .use_rs2 (use_rs2),
    .rs1     (rs1),
    .rs2     (rs2)
  );

  assign lu = id_valid & ex_valid & ex_mem_read & (ex_rd != 5'd0) &
              ((use_rs1 & (rs1 == ex_rd)) | (use_rs2 & (rs2 == ex_rd)));

  // Priority resolution of busy, redirect, flush and load-use; controls are combinational.
  always_comb begin
    nxt_state   = cur_state;
    fcnt_nxt    = fcnt;
    resume_nxt  = resume_flush;
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_hold  = 1'b0;
    if (!rst_n) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (mem_busy) begin
      exmem_hold = 1'b1;
      nxt_state  = MEM_WAIT;
      if (cur_state == FLUSH) begin
        resume_nxt = 1'b1;
      end else begin
        resume_nxt = resume_flush;
      end
    end else if (ex_redirect) begin
      pc_write    = 1'b1;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      fcnt_nxt    = FLUSH_INIT;
      resume_nxt  = 1'b0;
      nxt_state   = FLUSH;
    end else if ((cur_state == FLUSH) && (fcnt != 3'd0)) begin
      pc_write   = 1'b1;
      ifid_flush = 1'b1;
      fcnt_nxt   = fcnt - 3'd1;
      nxt_state  = (fcnt == 3'd1) ? RUN : FLUSH;
    end else if ((cur_state == RUN) && lu) begin
      idex_bubble = 1'b1;
      nxt_state   = LU_STALL;
    end else begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      // Leaving a wait that interrupted a flush resumes the remaining slots.
      if ((cur_state == MEM_WAIT) && resume_flush) begin
        nxt_state  = FLUSH;
        resume_nxt = 1'b0;
      end else begin
        nxt_state  = RUN;
        resume_nxt = 1'b0;
      end
    end
  end

  // FSM, flush counter and resume flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state    <= RUN;
      fcnt         <= 3'd0;
      resume_flush <= 1'b0;
    end else begin
      cur_state    <= nxt_state;
      fcnt         <= fcnt_nxt;
      resume_flush <= resume_nxt;
    end
  end

  // Saturating count of cycles where the PC did not advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (!pc_write && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end else begin
      stall_cnt <= stall_cnt;
    end
  end

  assign state = cur_state;

endmodule
